// File: rtl/spi_target_device_pkg.sv
// Shared constants for the SPI target peripheral: register offsets,
// CONFIG/STATUS bit positions and the byte sent when nothing is queued.
package spi_target_device_pkg;

    localparam logic [7:0] ADDR_CONFIG = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_TXDATA = 8'h08;
    localparam logic [7:0] ADDR_RXDATA = 8'h0C;

    localparam int CFG_ENABLE = 0;
    localparam int CFG_CPOL   = 1;
    localparam int CFG_CPHA   = 2;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_READY = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_UNDERRUN = 3;
    localparam int ST_ACTIVE   = 4;

    localparam logic [7:0] UNDERRUN_FILL = 8'hFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CONFIG,
        REG_STATUS,
        REG_TXDATA,
        REG_RXDATA
    } reg_sel_t;

    function automatic reg_sel_t decode_reg(input logic [7:0] offset);
        reg_sel_t sel;
        case (offset)
            ADDR_CONFIG: sel = REG_CONFIG;
            ADDR_STATUS: sel = REG_STATUS;
            ADDR_TXDATA: sel = REG_TXDATA;
            ADDR_RXDATA: sel = REG_RXDATA;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/spi_target_shifter.sv
// SPI pin synchroniser, SCLK edge detection and the 8-bit shift/bit-count
// engine. Byte loads and completions are reported as single-cycle pulses so
// the register file owns all flags.
module spi_target_shifter
    import spi_target_device_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       load,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       miso,
    output logic       active
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic [2:0]             bit_cnt;
    logic [7:0]             tx_sr;
    logic [6:0]             rx_sr;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic rise;
    logic fall;
    logic run;
    logic sample_edge;
    logic shift_edge;
    logic cs_assert;

    // Metastability chains; idle levels are cs high and sclk/mosi low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
        end
    end

    // Edges are taken on sclk ^ cpol so "rising" always means leading edge.
    assign sclk_s = clk_sync[SYNC_STAGES-1] ^ cpol;
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // Previous-cycle copies for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign rise        = sclk_s & ~sclk_prev;
    assign fall        = ~sclk_s & sclk_prev;
    assign active      = ~cs_s;
    assign run         = enable & active;
    assign sample_edge = run & (cpha ? fall : rise);
    assign shift_edge  = run & (cpha ? rise : fall);
    assign cs_assert   = cs_prev & ~cs_s;

    // cpha=0 presents the first bit before any clock, so load at cs fall;
    // cpha=1 loads on the first shift edge of every byte.
    assign load      = cpha ? (shift_edge && bit_cnt == 3'd0) : (run & cs_assert);
    assign byte_done = sample_edge && bit_cnt == 3'd7;
    assign rx_byte   = {rx_sr, mosi_s};
    assign miso      = tx_sr[7];

    // Shift engine; a partial byte is dropped whenever cs goes high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 7'h00;
        end else if (!enable) begin
            bit_cnt <= 3'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 7'h00;
        end else if (!active) begin
            bit_cnt <= 3'd0;
            rx_sr   <= 7'h00;
        end else begin
            if (load) begin
                tx_sr <= tx_valid ? tx_data : UNDERRUN_FILL;
            end else if (shift_edge) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (sample_edge) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/spi_target_device.sv
// SPI target peripheral: memory-mapped CONFIG/STATUS/TXDATA/RXDATA registers
// on the local bus, with the serial engine in spi_target_shifter.
module spi_target_device
    import spi_target_device_pkg::*;
#(
    parameter logic [7:0] ID          = 8'h01,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        peripheralEnable,
    input  logic        peripheralBus_we,
    input  logic        peripheralBus_oe,
    output logic        peripheralBus_busy,
    input  logic [15:0] peripheralBus_address,
    input  logic [3:0]  peripheralBus_byteSelect,
    input  logic [31:0] peripheralBus_dataWrite,
    output logic [31:0] peripheralBus_dataRead,
    output logic        requestOutput,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs,
    output logic        spi_miso,
    output logic        spi_miso_en
);

    logic [2:0] config_q;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       underrun;

    logic       selected;
    logic       wr_low;
    logic       rd_rx;
    reg_sel_t   reg_sel;
    logic [4:0] status;

    logic       load;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic       active;

    logic       unused_bits;
    assign unused_bits = ^{peripheralBus_dataWrite[31:8], peripheralBus_byteSelect[3:1]};

    assign selected           = peripheralEnable && (peripheralBus_address[15:8] == ID);
    assign reg_sel            = decode_reg(peripheralBus_address[7:0]);
    assign requestOutput      = selected & peripheralBus_oe;
    assign wr_low             = selected & peripheralBus_we & peripheralBus_byteSelect[0];
    assign rd_rx              = requestOutput && reg_sel == REG_RXDATA;
    assign peripheralBus_busy = 1'b0;

    spi_target_shifter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .enable   (config_q[CFG_ENABLE]),
        .cpol     (config_q[CFG_CPOL]),
        .cpha     (config_q[CFG_CPHA]),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_cs   (spi_cs),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .load     (load),
        .byte_done(byte_done),
        .rx_byte  (rx_byte),
        .miso     (spi_miso),
        .active   (active)
    );

    assign spi_miso_en = config_q[CFG_ENABLE] & active;

    // Assemble the STATUS word from the live flags.
    always_comb begin
        status              = '0;
        status[ST_RX_VALID] = rx_valid;
        status[ST_TX_READY] = ~tx_valid;
        status[ST_OVERRUN]  = overrun;
        status[ST_UNDERRUN] = underrun;
        status[ST_ACTIVE]   = active;
    end

    // Read mux; the bus idles at all-ones when not addressed.
    always_comb begin
        peripheralBus_dataRead = '1;
        if (requestOutput) begin
            case (reg_sel)
                REG_CONFIG: peripheralBus_dataRead = {29'b0, config_q};
                REG_STATUS: peripheralBus_dataRead = {27'b0, status};
                REG_TXDATA: peripheralBus_dataRead = {24'b0, tx_data};
                REG_RXDATA: peripheralBus_dataRead = {24'b0, rx_data};
                default:    peripheralBus_dataRead = '1;
            endcase
        end
    end

    // Register file. Statement order sets priority: flag clears by software
    // lose to same-cycle hardware events, a byte completion beats an RXDATA
    // read, and a TXDATA write lands after the load that consumed the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            config_q <= 3'b000;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_low && reg_sel == REG_CONFIG) begin
                config_q <= peripheralBus_dataWrite[2:0];
            end
            if (wr_low && reg_sel == REG_STATUS) begin
                if (peripheralBus_dataWrite[ST_OVERRUN]) overrun <= 1'b0;
                if (peripheralBus_dataWrite[ST_UNDERRUN]) underrun <= 1'b0;
            end
            if (load) begin
                tx_valid <= 1'b0;
                if (!tx_valid) underrun <= 1'b1;
            end
            if (byte_done) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
                if (rx_valid) overrun <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (wr_low && reg_sel == REG_TXDATA) begin
                tx_data  <= peripheralBus_dataWrite[7:0];
                tx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_target_device.sv
// Self-checking bench for spi_target_device: a register-access vector table,
// hand-written SPI scenarios and randomized frames against a byte-level model.
module tb_spi_target_device;

    localparam logic [7:0] ID      = 8'h01;
    localparam int         SYNC    = 2;
    localparam int         HP      = 5;
    localparam logic [15:0] A_CFG  = 16'h0100;
    localparam logic [15:0] A_STAT = 16'h0104;
    localparam logic [15:0] A_TX   = 16'h0108;
    localparam logic [15:0] A_RX   = 16'h010C;

    logic        clk = 1'b0;
    logic        rst;
    logic        pe, we, oe;
    logic        busy;
    logic [15:0] addr;
    logic [3:0]  bs;
    logic [31:0] wdata, rdata;
    logic        req;
    logic        sclk, mosi, cs;
    logic        miso, miso_en;

    int n_checks = 0;
    int n_fail   = 0;

    spi_target_device #(.ID(ID), .SYNC_STAGES(SYNC)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .peripheralEnable        (pe),
        .peripheralBus_we        (we),
        .peripheralBus_oe        (oe),
        .peripheralBus_busy      (busy),
        .peripheralBus_address   (addr),
        .peripheralBus_byteSelect(bs),
        .peripheralBus_dataWrite (wdata),
        .peripheralBus_dataRead  (rdata),
        .requestOutput           (req),
        .spi_clk                 (sclk),
        .spi_mosi                (mosi),
        .spi_cs                  (cs),
        .spi_miso                (miso),
        .spi_miso_en             (miso_en)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pe, we, oe;
        logic [15:0] addr;
        logic [3:0]  bs;
        logic [31:0] wd;
        logic        exp_req;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        pe = 1'b1; we = 1'b1; oe = 1'b0; addr = a; wdata = d; bs = b;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        pe = 1'b1; we = 1'b0; oe = 1'b1; addr = a;
        #1;
        d = rdata;
        @(negedge clk);
        oe = 1'b0;
    endtask

    // Half SCLK period; optionally reads RXDATA on the cycle the target
    // registers the sampled bit (SYNC flops plus the edge-detect flop).
    task automatic half(input bit rd);
        for (int k = 0; k < HP; k++) begin
            if (rd && k == SYNC) begin
                pe = 1'b1; oe = 1'b1; addr = A_RX;
            end else if (rd && k == SYNC + 1) begin
                oe = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic spi_begin();
        @(negedge clk);
        cs = 1'b0;
        half(0);
    endtask

    task automatic spi_end(input bit cpol);
        half(0);
        sclk = cpol;
        cs = 1'b1;
        half(0);
    endtask

    task automatic spi_byte(input bit cpol, input bit cpha, input logic [7:0] tx,
                            input int nbits, input bit rd_last, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                half(0);
                got[i] = miso;
                sclk = ~cpol;
                half(rd_last && i == 0);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = tx[i];
                half(0);
                got[i] = miso;
                sclk = cpol;
                half(rd_last && i == 0);
            end
        end
    endtask

    task automatic set_mode(input bit cpol, input bit cpha, input bit en);
        bus_write(A_CFG, {29'b0, cpha, cpol, en}, 4'h1);
        sclk = cpol;
        repeat (4) @(negedge clk);
    endtask

    logic [31:0] d;
    logic [7:0]  m, m2;

    // Byte-level model state for the randomized frames.
    bit          md_rxv, md_txv, md_ov, md_un;
    logic [7:0]  md_txd, md_rxd;

    initial begin
        rst = 1'b1; pe = 1'b0; we = 1'b0; oe = 1'b0; addr = '0; bs = '0; wdata = '0;
        sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'b0, miso}, 32'h0);
        check("rst_miso_en", {31'b0, miso_en}, 32'h0);
        check("rst_req", {31'b0, req}, 32'h0);
        check("rst_rdata", rdata, 32'hFFFF_FFFF);
        check("busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;

        // Register access table: {pe, we, oe, addr, bs, wd, exp_req, exp_rd}
        tbl[0]  = '{1, 0, 1, A_CFG,    4'h0, 32'h0,          1, 32'h0000_0000};
        tbl[1]  = '{1, 0, 1, A_STAT,   4'h0, 32'h0,          1, 32'h0000_0002};
        tbl[2]  = '{1, 0, 1, A_RX,     4'h0, 32'h0,          1, 32'h0000_0000};
        tbl[3]  = '{1, 0, 1, 16'h0210, 4'h0, 32'h0,          0, 32'hFFFF_FFFF};
        tbl[4]  = '{1, 0, 1, 16'h0110, 4'h0, 32'h0,          1, 32'hFFFF_FFFF};
        tbl[5]  = '{1, 0, 1, 16'h01FC, 4'h0, 32'h0,          1, 32'hFFFF_FFFF};
        tbl[6]  = '{0, 0, 1, A_CFG,    4'h0, 32'h0,          0, 32'hFFFF_FFFF};
        tbl[7]  = '{1, 1, 0, A_CFG,    4'hE, 32'hFFFF_FFFE,  0, 32'hFFFF_FFFF};
        tbl[8]  = '{1, 0, 1, A_CFG,    4'h0, 32'h0,          1, 32'h0000_0000};
        tbl[9]  = '{1, 1, 0, A_CFG,    4'h1, 32'hFFFF_FFFF,  0, 32'hFFFF_FFFF};
        tbl[10] = '{1, 0, 1, A_CFG,    4'h0, 32'h0,          1, 32'h0000_0007};
        tbl[11] = '{0, 1, 0, A_CFG,    4'hF, 32'h0,          0, 32'hFFFF_FFFF};
        tbl[12] = '{1, 0, 1, A_CFG,    4'h0, 32'h0,          1, 32'h0000_0007};
        tbl[13] = '{1, 1, 0, A_CFG,    4'h1, 32'h0000_0001,  0, 32'hFFFF_FFFF};
        tbl[14] = '{1, 0, 1, A_CFG,    4'h0, 32'h0,          1, 32'h0000_0001};
        tbl[15] = '{1, 1, 0, A_TX,     4'hE, 32'h1234_5678,  0, 32'hFFFF_FFFF};
        tbl[16] = '{1, 0, 1, A_STAT,   4'h0, 32'h0,          1, 32'h0000_0002};
        tbl[17] = '{1, 1, 0, A_TX,     4'h1, 32'h0000_01A5,  0, 32'hFFFF_FFFF};
        tbl[18] = '{1, 0, 1, A_STAT,   4'h0, 32'h0,          1, 32'h0000_0000};
        tbl[19] = '{1, 1, 0, A_STAT,   4'h1, 32'h0000_000C,  0, 32'hFFFF_FFFF};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pe = tbl[i].pe; we = tbl[i].we; oe = tbl[i].oe;
            addr = tbl[i].addr; bs = tbl[i].bs; wdata = tbl[i].wd;
            #1;
            check($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, tbl[i].exp_req});
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
        end
        @(negedge clk);
        we = 1'b0; oe = 1'b0; bs = 4'h0;

        // Mode 0: TXDATA=0xA5 queued by the table, controller sends 0x3C.
        spi_begin();
        check("m0_miso_en", {31'b0, miso_en}, 32'h1);
        spi_byte(0, 0, 8'h3C, 8, 0, m);
        spi_end(0);
        check("m0_miso", {24'b0, m}, 32'hA5);
        bus_read(A_STAT, d); check("m0_status", d, 32'h03);
        bus_read(A_RX, d);   check("m0_rx", d, 32'h3C);
        bus_read(A_STAT, d); check("m0_status_after_rd", d, 32'h02);

        // cs released after 5 bits: partial byte discarded, then 0x81.
        spi_begin();
        spi_byte(0, 0, 8'hFF, 5, 0, m);
        spi_end(0);
        bus_read(A_STAT, d); check("abort_status", d, 32'h0A);
        bus_read(A_RX, d);   check("abort_rx", d, 32'h3C);
        bus_write(A_STAT, 32'h08, 4'h1);
        bus_read(A_STAT, d); check("clr_underrun", d, 32'h02);
        bus_write(A_TX, 32'h5A, 4'h1);
        spi_begin();
        spi_byte(0, 0, 8'h81, 8, 0, m);
        spi_end(0);
        check("after_abort_miso", {24'b0, m}, 32'h5A);
        bus_read(A_STAT, d); check("after_abort_status", d, 32'h03);
        bus_read(A_RX, d);   check("after_abort_rx", d, 32'h81);

        // RXDATA read in the completion cycle of 0x55 keeps rxValid set.
        bus_write(A_TX, 32'h66, 4'h1);
        spi_begin();
        spi_byte(0, 0, 8'h55, 8, 1, m);
        spi_end(0);
        check("race_miso", {24'b0, m}, 32'h66);
        bus_read(A_STAT, d); check("race_status", d, 32'h03);
        bus_read(A_RX, d);   check("race_rx", d, 32'h55);

        // Mode 3, two bytes, no refill and no read in between.
        set_mode(1, 1, 1);
        bus_write(A_TX, 32'hC3, 4'h1);
        spi_begin();
        spi_byte(1, 1, 8'h12, 8, 0, m);
        spi_byte(1, 1, 8'h34, 8, 0, m2);
        spi_end(1);
        check("m3_miso0", {24'b0, m}, 32'hC3);
        check("m3_miso1", {24'b0, m2}, 32'hFF);
        bus_read(A_STAT, d); check("m3_status", d, 32'h0F);
        bus_read(A_RX, d);   check("m3_rx", d, 32'h34);
        bus_write(A_STAT, 32'h0C, 4'h1);
        bus_read(A_STAT, d); check("m3_clr", d, 32'h02);

        // Disabled: SPI traffic ignored, registers still accessible.
        set_mode(0, 0, 0);
        bus_write(A_TX, 32'h11, 4'h1);
        spi_begin();
        check("dis_miso_en", {31'b0, miso_en}, 32'h0);
        spi_byte(0, 0, 8'h99, 8, 0, m);
        check("dis_miso", {24'b0, m}, 32'h00);
        spi_end(0);
        bus_read(A_STAT, d); check("dis_status", d, 32'h00);
        bus_read(A_RX, d);   check("dis_rx", d, 32'h34);

        // Reset in the middle of a byte.
        set_mode(0, 0, 1);
        spi_begin();
        spi_byte(0, 0, 8'hF0, 4, 0, m);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_miso", {31'b0, miso}, 32'h0);
        check("mid_rst_miso_en", {31'b0, miso_en}, 32'h0);
        check("mid_rst_req", {31'b0, req}, 32'h0);
        check("mid_rst_rdata", rdata, 32'hFFFF_FFFF);
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(A_CFG, d);  check("post_rst_cfg", d, 32'h0);
        bus_read(A_STAT, d); check("post_rst_status", d, 32'h02);
        bus_read(A_RX, d);   check("post_rst_rx", d, 32'h0);
        set_mode(0, 0, 1);
        bus_write(A_TX, 32'h77, 4'h1);
        spi_begin();
        spi_byte(0, 0, 8'hE7, 8, 0, m);
        spi_end(0);
        check("post_rst_miso", {24'b0, m}, 32'h77);
        bus_read(A_RX, d);   check("post_rst_xfer_rx", d, 32'hE7);

        // Randomized frames against a byte-level model.
        md_rxv = 0; md_txv = 0; md_ov = 0; md_un = 0; md_txd = 8'h77; md_rxd = 8'hE7;
        for (int f = 0; f < 16; f++) begin
            bit cpol, cpha;
            int nb;
            logic [7:0] exp_m, mo;
            cpol = 1'($urandom_range(0, 1));
            cpha = 1'($urandom_range(0, 1));
            nb   = cpha ? int'($urandom_range(1, 3)) : 1;
            set_mode(cpol, cpha, 1);
            if ($urandom_range(0, 1) == 1) begin
                mo = 8'($urandom);
                bus_write(A_TX, {24'b0, mo}, 4'h1);
                md_txv = 1; md_txd = mo;
            end
            spi_begin();
            for (int b = 0; b < nb; b++) begin
                if (cpha && b > 0 && $urandom_range(0, 1) == 1) begin
                    mo = 8'($urandom);
                    bus_write(A_TX, {24'b0, mo}, 4'h1);
                    md_txv = 1; md_txd = mo;
                end
                if (md_txv) begin
                    exp_m = md_txd; md_txv = 0;
                end else begin
                    exp_m = 8'hFF; md_un = 1;
                end
                mo = 8'($urandom);
                spi_byte(cpol, cpha, mo, 8, 0, m);
                check($sformatf("rand%0d_b%0d_miso", f, b), {24'b0, m}, {24'b0, exp_m});
                if (md_rxv) md_ov = 1;
                md_rxd = mo; md_rxv = 1;
                if ($urandom_range(0, 1) == 1) begin
                    bus_read(A_RX, d);
                    check($sformatf("rand%0d_b%0d_rx", f, b), d, {24'b0, md_rxd});
                    md_rxv = 0;
                end
            end
            spi_end(cpol);
            bus_read(A_STAT, d);
            check($sformatf("rand%0d_status", f), d,
                  {28'b0, md_un, md_ov, ~md_txv, md_rxv});
            if ($urandom_range(0, 3) == 0) begin
                int c;
                c = int'($urandom_range(0, 3));
                bus_write(A_STAT, 32'(c) << 2, 4'h1);
                if (c[0]) md_ov = 0;
                if (c[1]) md_un = 0;
            end
        end
        bus_read(A_RX, d);
        check("rand_final_rx", d, {24'b0, md_rxd});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_target_device.md
SPI_TARGET_DEVICE -- requirements
Module: spi_target_device

Interface
REQ-001 SHALL have parameter ID, default 8'h01, device select value compared against peripheralBus_address[15:8].
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for SPI inputs (minimum 2).
REQ-003 SHALL have the following ports, in this order:
- clk  input  1  the only clock.
- rst  input  1  reset; asynchronous, active-high.
- peripheralEnable  input  1  peripheral-level select.
- peripheralBus_we  input  1  write strobe.
- peripheralBus_oe  input  1  read strobe.
- peripheralBus_busy  output  1  bus stall.
- peripheralBus_address  input  16  local address.
- peripheralBus_byteSelect  input  4  byte enables.
- peripheralBus_dataWrite  input  32  write data.
- peripheralBus_dataRead  output  32  read data.
- requestOutput  output  1  read data valid, for the parent mux.
- spi_clk  input  1  SCLK from the external controller.
- spi_mosi  input  1  controller-to-target data.
- spi_cs  input  1  chip select, active-low.
- spi_miso  output  1  target-to-controller data.
- spi_miso_en  output  1  MISO pad output enable.

Function
REQ-004 SHALL decode the device as selected when peripheralEnable=1 and address[15:8]==ID; registers at address[7:0]: 0x00 CONFIG, 0x04 STATUS, 0x08 TXDATA, 0x0C RXDATA; other offsets read ~32'b0.
REQ-005 CONFIG SHALL be R/W, bits used only when byteSelect[0]=1: [0] enable, [1] cpol, [2] cpha; remaining bits read 0.
REQ-006 STATUS SHALL read: [0] rxValid, [1] txReady (=!txValid), [2] overrun, [3] underrun, [4] active (synchronised cs low); writing 1 to bit 2 or bit 3 with byteSelect[0]=1 SHALL clear that bit.
REQ-007 A write to TXDATA with byteSelect[0]=1 SHALL store bits [7:0] and set txValid.
REQ-008 A read of RXDATA SHALL return the byte in bits [7:0], zero-extended, and SHALL clear rxValid at the end of that cycle.
REQ-009 peripheralBus_busy SHALL be constant 0; requestOutput SHALL equal selected & oe, combinationally; dataRead SHALL be combinational and ~32'b0 when requestOutput=0.
REQ-010 spi_clk, spi_mosi and spi_cs SHALL pass through SYNC_STAGES flops; edges SHALL be detected on synchronised (spi_clk ^ cpol).
REQ-011 Sample edge SHALL be the rising edge of (spi_clk ^ cpol) when cpha=0 and the falling edge when cpha=1; the shift edge SHALL be the opposite edge; transfers SHALL be 8 bits, MSB first.
REQ-012 Byte load SHALL occur at cs assertion when cpha=0, and at the first shift edge of each byte when cpha=1.
REQ-013 Byte load SHALL load TXDATA into the shift register and clear txValid; if txValid=0, it SHALL load 8'hFF and set underrun.
REQ-014 On the 8th sample edge the assembled byte SHALL be written to RXDATA, rxValid SHALL be set, and if rxValid was already 1, overrun SHALL be set (new data overwrites).
REQ-015 spi_miso SHALL present shift-register MSB; spi_miso_en = enable & active.
REQ-016 cs deasserting mid-byte SHALL reset the bit counter to 0 and discard the partial byte; rxValid, RXDATA and TXDATA SHALL be unaffected.
REQ-017 enable=0 SHALL hold the bit counter and shift register at 0 and ignore SPI edges; register access SHALL remain functional.
REQ-018 On the same cycle, a byte completion SHALL take priority over an RXDATA read, so rxValid stays 1.
REQ-019 On the same cycle, a TXDATA write SHALL be evaluated after a byte load: the load uses the old txValid, and the write leaves txValid=1.
REQ-020 Correct operation SHALL require a spi_clk half-period of at least 4 clk cycles.

Reset
REQ-021 On rst, all state SHALL clear asynchronously: CONFIG=0, TXDATA=0, RXDATA=0, all flags 0, bit counter 0, synchroniser flops at idle (cs=1, clk=cpol-neutral 0); hence spi_miso=0, spi_miso_en=0, requestOutput=0, dataRead=~32'b0.

Structure
REQ-022 A shared package SHALL hold register offsets, CONFIG and STATUS bit indices, and the underrun fill value 8'hFF.
REQ-023 Synchroniser, edge detect and shift/bit-count logic SHALL be one sub-module, spi_target_shifter; register file and bus decode SHALL stay in the top module.

Verification
REQ-024 Mode 0: write TXDATA=0xA5, then controller sends 0x3C -> MISO shifts 0xA5, RXDATA=0x3C, STATUS=0x03 after cs high (rxValid=1, txReady=1).
REQ-025 Mode 3 (cpol=1, cpha=1), two bytes 0x12, 0x34 with no RXDATA read and no TXDATA refill -> RXDATA=0x34, overrun=1, underrun=1, second MISO byte 0xFF.
REQ-026 cs high after 5 bits of 0xFF -> RXDATA unchanged, rxValid=0; the next full byte 0x81 is received correctly.
REQ-027 RXDATA read on the same cycle as completion of 0x55 -> rxValid remains 1, RXDATA=0x55.
REQ-028 rst asserted mid-byte -> all outputs at reset values immediately; the next transfer after enable=1 is received correctly.
REQ-029 Read of address 0x0210 with ID=1 -> requestOutput=0; read of 0x0110 -> requestOutput=1, dataRead=~32'b0.
